// File: rtl/dll_pkg.sv
// Shared widths, code constants and FSM encoding for the FMDLL delay-code controller.
package dll_pkg;
   localparam int QW       = 10;
   localparam int MW       = 2;
   localparam int NW       = 4;
   localparam int LOCK_CNT = 4;
   localparam int KW       = $clog2(QW);
   localparam int LCW      = $clog2(LOCK_CNT + 1);

   localparam logic [QW-1:0]  QMID     = 10'h200;
   localparam logic [QW-1:0]  QMAX     = '1;
   localparam logic [QW-1:0]  Q_ONE    = 1;
   localparam logic [KW-1:0]  K_ONE    = 1;
   localparam logic [KW-1:0]  K_TOP    = KW'(QW - 1);
   localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SAR   = 2'd1,
      ST_TRACK = 2'd2
   } dll_state_e;
endpackage

// File: rtl/dll_frame_cnt.sv
// Free-running M/N frame counters with zero-as-one clamping and the frame_end strobe.
module dll_frame_cnt
   import dll_pkg::*;
(
   input  logic          clk_ext,
   input  logic          Reset_SAR,
   input  logic          i_restart,
   input  logic [MW-1:0] i_m,
   input  logic [NW-1:0] i_n,
   output logic [MW-1:0] o_m_cnt,
   output logic [NW-1:0] o_n_cnt,
   output logic          o_frame_end
);
   localparam logic [MW-1:0] M_ONE = 1;
   localparam logic [NW-1:0] N_ONE = 1;

   logic [MW-1:0] w_m_eff;
   logic [NW-1:0] w_n_eff;
   logic [MW-1:0] r_m_cnt;
   logic [NW-1:0] r_n_cnt;

   assign w_m_eff = (i_m == '0) ? M_ONE : i_m;
   assign w_n_eff = (i_n == '0) ? N_ONE : i_n;

   // ">=" rather than "==" so a counter stranded above a shrunken limit wraps next cycle.
   always_ff @(posedge clk_ext or posedge Reset_SAR) begin
      if (Reset_SAR) begin
         r_m_cnt <= M_ONE;
         r_n_cnt <= N_ONE;
      end else if (i_restart) begin
         r_m_cnt <= M_ONE;
         r_n_cnt <= N_ONE;
      end else if (r_n_cnt >= w_n_eff) begin
         r_n_cnt <= N_ONE;
         r_m_cnt <= (r_m_cnt >= w_m_eff) ? M_ONE : r_m_cnt + M_ONE;
      end else begin
         r_n_cnt <= r_n_cnt + N_ONE;
         if (r_m_cnt > w_m_eff) r_m_cnt <= M_ONE;
      end
   end

   assign o_m_cnt     = r_m_cnt;
   assign o_n_cnt     = r_n_cnt;
   assign o_frame_end = (r_m_cnt == w_m_eff) && (r_n_cnt == w_n_eff);
endmodule

// File: rtl/dll_sar_ctrl.sv
// FMDLL delay-code controller: SAR search from midscale, then +/-1 LSB tracking with lock detect.
module dll_sar_ctrl
   import dll_pkg::*;
(
   input  logic          clk_ext,
   input  logic          Reset_SAR,
   input  logic          start,
   input  logic [MW-1:0] M,
   input  logic [NW-1:0] N,
   input  logic          COMP,
   output logic [MW-1:0] M_counter,
   output logic [NW-1:0] N_counter,
   output logic [QW-1:0] Q,
   output logic [QW-1:0] Q_next,
   output logic          frame_end,
   output logic          busy,
   output logic          lock,
   output dll_state_e    o_dbg_state
);
   dll_state_e     r_state;
   dll_state_e     w_state_nxt;
   logic [KW-1:0]  r_k;
   logic [QW-1:0]  r_q;
   logic [QW-1:0]  w_q_nxt;
   logic [QW-1:0]  w_bit_k;
   logic [QW-1:0]  w_bit_lo;
   logic [LCW-1:0] r_rev;
   logic [LCW-1:0] w_rev_inc;
   logic           r_prev_dir;
   logic           r_lock;
   logic           w_frame_end;

   dll_frame_cnt u_frame_cnt (
      .clk_ext     (clk_ext),
      .Reset_SAR   (Reset_SAR),
      .i_restart   (start),
      .i_m         (M),
      .i_n         (N),
      .o_m_cnt     (M_counter),
      .o_n_cnt     (N_counter),
      .o_frame_end (w_frame_end)
   );

   assign w_bit_k   = Q_ONE << r_k;
   assign w_bit_lo  = Q_ONE << (r_k - K_ONE);
   assign w_rev_inc = (r_rev == LOCK_MAX) ? r_rev : r_rev + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      case (r_state)
         ST_SAR: begin
            // The trial bit k is already set in Q: keep or clear it, then trial bit k-1.
            if (r_k == '0) begin
               w_q_nxt = COMP ? r_q : (r_q & ~Q_ONE);
               if (w_frame_end) w_state_nxt = ST_TRACK;
            end else begin
               w_q_nxt = COMP ? (r_q | w_bit_lo) : ((r_q & ~w_bit_k) | w_bit_lo);
            end
         end
         ST_TRACK: begin
            if (COMP) w_q_nxt = (r_q == QMAX) ? r_q : r_q + Q_ONE;
            else      w_q_nxt = (r_q == '0)   ? r_q : r_q - Q_ONE;
         end
         default: begin
            w_state_nxt = r_state;
            w_q_nxt     = r_q;
         end
      endcase
   end

   always_ff @(posedge clk_ext or posedge Reset_SAR) begin
      if (Reset_SAR) begin
         r_state    <= ST_IDLE;
         r_k        <= K_TOP;
         r_q        <= QMID;
         r_rev      <= '0;
         r_prev_dir <= 1'b0;
         r_lock     <= 1'b0;
      end else if (start) begin
         r_state    <= ST_SAR;
         r_k        <= K_TOP;
         r_q        <= QMID;
         r_rev      <= '0;
         r_lock     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_frame_end && (r_state != ST_IDLE)) begin
            r_q        <= w_q_nxt;
            r_prev_dir <= COMP;
            if ((r_state == ST_SAR) && (r_k != '0)) r_k <= r_k - K_ONE;
            // A saturated step still carries a direction for reversal counting.
            if (r_state == ST_TRACK) begin
               if (COMP != r_prev_dir) begin
                  r_rev  <= w_rev_inc;
                  r_lock <= (w_rev_inc == LOCK_MAX);
               end else begin
                  r_rev  <= '0;
                  r_lock <= 1'b0;
               end
            end
         end
      end
   end

   assign Q           = r_q;
   assign Q_next      = w_q_nxt;
   assign frame_end   = w_frame_end;
   assign busy        = (r_state == ST_SAR);
   assign lock        = r_lock;
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dll_sar_ctrl.sv
// Bench for dll_sar_ctrl: frame_end-driven scoreboard of {busy, lock, Q_next} plus direct checks.
module tb_dll_sar_ctrl;
   import dll_pkg::*;

   logic          clk_ext = 1'b0;
   logic          Reset_SAR = 1'b0;
   logic          start = 1'b0;
   logic [MW-1:0] M = 2'd2;
   logic [NW-1:0] N = 4'd3;
   logic          COMP;
   logic [MW-1:0] M_counter;
   logic [NW-1:0] N_counter;
   logic [QW-1:0] Q;
   logic [QW-1:0] Q_next;
   logic          frame_end;
   logic          busy;
   logic          lock;
   dll_state_e    o_dbg_state;

   logic [QW+1:0] exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   bit            mon_en = 1'b0;
   bit            comp_mode = 1'b0;
   bit            comp_force = 1'b0;
   logic [QW-1:0] target = 10'h2A5;

   dll_sar_ctrl dut (
      .clk_ext     (clk_ext),
      .Reset_SAR   (Reset_SAR),
      .start       (start),
      .M           (M),
      .N           (N),
      .COMP        (COMP),
      .M_counter   (M_counter),
      .N_counter   (N_counter),
      .Q           (Q),
      .Q_next      (Q_next),
      .frame_end   (frame_end),
      .busy        (busy),
      .lock        (lock),
      .o_dbg_state (o_dbg_state)
   );

   always #5 clk_ext = ~clk_ext;

   // Phase-detector stand-in: either a fixed decision or "raise while Q <= target".
   always_comb COMP = comp_mode ? comp_force : (Q <= target);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every frame_end while enabled pops one expected {busy, lock, Q_next}.
   always @(negedge clk_ext) begin
      if (mon_en && frame_end && !Reset_SAR) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL frame_unexpected: got 0x%0h expected none", {busy, lock, Q_next});
         end else begin
            logic [QW+1:0] e;
            e = exp_q.pop_front();
            if ({busy, lock, Q_next} !== e) begin
               n_err++;
               $display("FAIL frame_out: got 0x%0h expected 0x%0h", {busy, lock, Q_next}, e);
            end
         end
      end
   end

   task automatic wait_drain(input int max_cyc);
      bit done;
      done = 1'b0;
      for (int c = 0; c < max_cyc && !done; c++) begin
         @(posedge clk_ext);
         #2;
         if (exp_q.size() == 0) done = 1'b1;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic push(input bit b, input bit l, input logic [QW-1:0] q);
      exp_q.push_back({b, l, q});
   endtask

   task automatic pulse_start();
      @(negedge clk_ext);
      start = 1'b1;
      @(negedge clk_ext);
      start = 1'b0;
   endtask

   task automatic do_frame(input bit c, input bit l, input logic [QW-1:0] q);
      comp_force = c;
      push(1'b0, l, q);
      wait_drain(20);
   endtask

   task automatic push_search_2a5();
      push(1, 0, 10'h300); push(1, 0, 10'h280); push(1, 0, 10'h2C0);
      push(1, 0, 10'h2A0); push(1, 0, 10'h2B0); push(1, 0, 10'h2A8);
      push(1, 0, 10'h2A4); push(1, 0, 10'h2A6); push(1, 0, 10'h2A5);
      push(1, 0, 10'h2A5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset asserted between clock edges takes effect immediately.
      #2 Reset_SAR = 1'b1;
      #1;
      check("rst_q", Q, 10'h200);
      check("rst_mcnt", M_counter, 1);
      check("rst_ncnt", N_counter, 1);
      check("rst_busy", busy, 0);
      check("rst_lock", lock, 0);
      check("rst_state", o_dbg_state, ST_IDLE);
      @(negedge clk_ext);
      Reset_SAR = 1'b0;

      // Counters run in IDLE: M=2,N=3 gives frame_end on every 6th cycle.
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk_ext);
         check("fe_m2n3", frame_end, (i % 6) == 5);
         if (i == 5) begin
            check("fe_mcnt", M_counter, 2);
            check("fe_ncnt", N_counter, 3);
         end
      end
      check("idle_qnext", Q_next, 10'h200);
      M = 2'd0;
      N = 4'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_ext);
         check("fe_m0n0", frame_end, 1);
         check("cnt_m0n0", {M_counter, N_counter}, {2'd1, 4'd1});
      end
      check("idle_q", Q, 10'h200);

      // SAR search toward 0x2A5 with two-cycle frames.
      M = 2'd1;
      N = 4'd2;
      comp_mode = 1'b0;
      pulse_start();
      check("start_q", Q, 10'h200);
      check("start_busy", busy, 1);
      check("start_cnt", {M_counter, N_counter}, {2'd1, 4'd1});
      mon_en = 1'b1;
      push_search_2a5();
      wait_drain(60);
      mon_en = 1'b0;
      check("search_q", Q, 10'h2A5);
      check("search_busy", busy, 0);
      check("search_state", o_dbg_state, ST_TRACK);

      // All-ones search, then saturation at 0x3FF in TRACK.
      comp_mode = 1'b1;
      comp_force = 1'b1;
      pulse_start();
      mon_en = 1'b1;
      push(1, 0, 10'h300); push(1, 0, 10'h380); push(1, 0, 10'h3C0);
      push(1, 0, 10'h3E0); push(1, 0, 10'h3F0); push(1, 0, 10'h3F8);
      push(1, 0, 10'h3FC); push(1, 0, 10'h3FE); push(1, 0, 10'h3FF);
      push(1, 0, 10'h3FF);
      push(0, 0, 10'h3FF); push(0, 0, 10'h3FF); push(0, 0, 10'h3FF);
      wait_drain(80);
      check("sat_q", Q, 10'h3FF);
      check("sat_lock", lock, 0);

      // Alternating decisions: four reversals set lock; two equal ones clear it.
      do_frame(0, 0, 10'h3FE);
      do_frame(1, 0, 10'h3FF);
      do_frame(0, 0, 10'h3FE);
      do_frame(1, 0, 10'h3FF);
      check("lock_set", lock, 1);
      do_frame(1, 1, 10'h3FF);
      do_frame(1, 0, 10'h3FF);
      mon_en = 1'b0;
      check("lock_clr", lock, 0);

      // Restart coincident with the 5th SAR frame_end: start wins, search reruns.
      comp_mode = 1'b0;
      pulse_start();
      mon_en = 1'b1;
      push(1, 0, 10'h300); push(1, 0, 10'h280); push(1, 0, 10'h2C0);
      push(1, 0, 10'h2A0);
      wait_drain(40);
      mon_en = 1'b0;
      @(negedge clk_ext);
      @(negedge clk_ext);
      check("f5_frame_end", frame_end, 1);
      check("f5_q", Q, 10'h2A0);
      start = 1'b1;
      @(posedge clk_ext);
      #1;
      check("restart_q", Q, 10'h200);
      check("restart_cnt", {M_counter, N_counter}, {2'd1, 4'd1});
      check("restart_busy", busy, 1);
      @(negedge clk_ext);
      start = 1'b0;
      mon_en = 1'b1;
      push_search_2a5();
      wait_drain(60);
      mon_en = 1'b0;
      check("rerun_q", Q, 10'h2A5);
      check("rerun_busy", busy, 0);

      // Reset mid-operation, away from any clock edge.
      repeat (3) @(posedge clk_ext);
      #3 Reset_SAR = 1'b1;
      #1;
      check("mrst_q", Q, 10'h200);
      check("mrst_cnt", {M_counter, N_counter}, {2'd1, 4'd1});
      check("mrst_busy", busy, 0);
      check("mrst_lock", lock, 0);
      @(negedge clk_ext);
      Reset_SAR = 1'b0;
      comp_mode = 1'b1;
      comp_force = 1'b0;
      repeat (6) @(negedge clk_ext);
      check("mrst_idle_q", Q, 10'h200);
      check("mrst_idle_state", o_dbg_state, ST_IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
